// File: rtl/tdp_ram_pkg.sv
// Shared constants for the true dual-port RAM.
//   RD_FIRST / WR_FIRST : values of the RD_MODE parameter (cross-port read-during-write).
//   clr_state_e         : encoding of the clear sequencer states.
package tdp_ram_pkg;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/tdp_ram_clear_fsm.sv
// Clear sequencer: on clear_req walks addresses 0..DEPTH-1, one per cycle, and
// strobes a zero write for each one.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_req  : start a clear (ignored while busy)
//   busy       : clear in progress (ports must be blocked)
//   clr_addr   : address being cleared this cycle
//   clr_we     : write zero to clr_addr at the next edge
//   clear_done : one-cycle pulse after the last address is cleared
module tdp_ram_clear_fsm
  import tdp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we,
  output logic                  clear_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == StClear);
  assign clr_we     = busy;
  assign clr_addr   = cnt_q;
  assign clear_done = done_q;

endmodule

// File: rtl/true_dual_port_ram.sv
// True dual-port RAM with byte enables, bulk clear and write/write collision flag.
//   clk, rst                       : clock, asynchronous active-high reset
//   en_x, we_x, addr_x, wdata_x,
//   wbe_x                          : port x request (x = a, b)
//   rdata_x, rvalid_x              : registered read data, one-cycle valid pulse
//   clear_req, busy, clear_done    : bulk clear request / in progress / finished pulse
//   coll                           : pulse after both ports wrote the same address
module true_dual_port_ram
  import tdp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_MODE    = RD_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  input  logic [DATA_WIDTH/8-1:0] wbe_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  input  logic [DATA_WIDTH/8-1:0] wbe_b,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  output logic                    rvalid_b,
  input  logic                    clear_req,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    coll
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  tdp_ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .clr_addr   (clr_addr),
    .clr_we     (clr_we),
    .clear_done (clear_done)
  );

  logic             in_a, in_b, same_addr;
  logic             rd_a, rd_b, wr_a, wr_b, wr_b_kept;
  logic [IDX_W-1:0] idx_a, idx_b, idx_clr;

  assign in_a      = ({1'b0, addr_a} < DEPTH_W);
  assign in_b      = ({1'b0, addr_b} < DEPTH_W);
  assign same_addr = (addr_a == addr_b);
  assign idx_a     = addr_a[IDX_W-1:0];
  assign idx_b     = addr_b[IDX_W-1:0];
  assign idx_clr   = clr_addr[IDX_W-1:0];

  // Out-of-range reads are still accepted (they return zero); out-of-range writes are dropped.
  assign rd_a      = en_a & ~we_a & ~busy;
  assign rd_b      = en_b & ~we_b & ~busy;
  assign wr_a      = en_a & we_a & ~busy & in_a;
  assign wr_b      = en_b & we_b & ~busy & in_b;
  // Port A owns the whole word on a same-address write/write.
  assign wr_b_kept = wr_b & ~(wr_a & same_addr);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[idx_clr] <= '0;
    end else begin
      if (wr_a)      mem[idx_a] <= merge_bytes(mem[idx_a], wdata_a, wbe_a);
      if (wr_b_kept) mem[idx_b] <= merge_bytes(mem[idx_b], wdata_b, wbe_b);
    end
  end

  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  always_comb begin
    rd_word_a = '0;
    if (in_a) begin
      rd_word_a = mem[idx_a];
      if ((RD_MODE == WR_FIRST) && wr_b_kept && same_addr) begin
        rd_word_a = merge_bytes(rd_word_a, wdata_b, wbe_b);
      end
    end
  end

  always_comb begin
    rd_word_b = '0;
    if (in_b) begin
      rd_word_b = mem[idx_b];
      if ((RD_MODE == WR_FIRST) && wr_a && same_addr) begin
        rd_word_b = merge_bytes(rd_word_b, wdata_a, wbe_a);
      end
    end
  end

  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
  logic                  rvalid_a_q, rvalid_b_q, coll_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      coll_q     <= wr_a & wr_b & same_addr;
      if (rd_a) rdata_a_q <= rd_word_a;
      if (rd_b) rdata_b_q <= rd_word_b;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign coll     = coll_q;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Self-checking bench: two instances (read-first and write-first) share all inputs and are
// compared every cycle against an array-based reference model.
module tb_true_dual_port_ram;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;

  logic          clk, rst;
  logic          en_a, we_a, en_b, we_b, clear_req;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [NB-1:0] wbe_a, wbe_b;

  logic [DW-1:0] rdata_a_rf, rdata_b_rf, rdata_a_wf, rdata_b_wf;
  logic          rvalid_a_rf, rvalid_b_rf, busy_rf, done_rf, coll_rf;
  logic          rvalid_a_wf, rvalid_b_wf, busy_wf, done_wf, coll_wf;

  true_dual_port_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_MODE    (0)
  ) dut_rf (
    .clk        (clk),
    .rst        (rst),
    .en_a       (en_a),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .wdata_a    (wdata_a),
    .wbe_a      (wbe_a),
    .rdata_a    (rdata_a_rf),
    .rvalid_a   (rvalid_a_rf),
    .en_b       (en_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .wdata_b    (wdata_b),
    .wbe_b      (wbe_b),
    .rdata_b    (rdata_b_rf),
    .rvalid_b   (rvalid_b_rf),
    .clear_req  (clear_req),
    .busy       (busy_rf),
    .clear_done (done_rf),
    .coll       (coll_rf)
  );

  true_dual_port_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_MODE    (1)
  ) dut_wf (
    .clk        (clk),
    .rst        (rst),
    .en_a       (en_a),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .wdata_a    (wdata_a),
    .wbe_a      (wbe_a),
    .rdata_a    (rdata_a_wf),
    .rvalid_a   (rvalid_a_wf),
    .en_b       (en_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .wdata_b    (wdata_b),
    .wbe_b      (wbe_b),
    .rdata_b    (rdata_b_wf),
    .rvalid_b   (rvalid_b_wf),
    .clear_req  (clear_req),
    .busy       (busy_wf),
    .clear_done (done_wf),
    .coll       (coll_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_pos;  // next address to clear, -1 when no clear is running
  logic [DW-1:0] exp_ra_rf, exp_ra_wf, exp_rb_rf, exp_rb_wf;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check_all(input logic e_rva, input logic e_rvb, input logic e_coll,
                           input logic e_done);
    check("rvalid_a_rf", rvalid_a_rf, e_rva);
    check("rvalid_a_wf", rvalid_a_wf, e_rva);
    check("rvalid_b_rf", rvalid_b_rf, e_rvb);
    check("rvalid_b_wf", rvalid_b_wf, e_rvb);
    check("rdata_a_rf", rdata_a_rf, exp_ra_rf);
    check("rdata_a_wf", rdata_a_wf, exp_ra_wf);
    check("rdata_b_rf", rdata_b_rf, exp_rb_rf);
    check("rdata_b_wf", rdata_b_wf, exp_rb_wf);
    check("coll_rf", coll_rf, e_coll);
    check("coll_wf", coll_wf, e_coll);
    check("busy_rf", busy_rf, clr_pos >= 0);
    check("busy_wf", busy_wf, clr_pos >= 0);
    check("done_rf", done_rf, e_done);
    check("done_wf", done_wf, e_done);
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic ea, input logic wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic [NB-1:0] ba,
                      input logic eb, input logic wb, input logic [AW-1:0] ab,
                      input logic [DW-1:0] db, input logic [NB-1:0] bb, input logic cr);
    bit busy_m, in_a, in_b, same, rd_a, rd_b, wr_a, wr_b, wr_bk, e_coll, e_done;
    en_a = ea; we_a = wa; addr_a = aa; wdata_a = da; wbe_a = ba;
    en_b = eb; we_b = wb; addr_b = ab; wdata_b = db; wbe_b = bb;
    clear_req = cr;

    busy_m = (clr_pos >= 0);
    in_a   = (int'(aa) < DEPTH);
    in_b   = (int'(ab) < DEPTH);
    same   = (aa == ab);
    rd_a   = ea && !wa && !busy_m;
    rd_b   = eb && !wb && !busy_m;
    wr_a   = ea && wa && !busy_m && in_a;
    wr_b   = eb && wb && !busy_m && in_b;
    wr_bk  = wr_b && !(wr_a && same);
    e_coll = wr_a && wr_b && same;
    e_done = 1'b0;

    if (rd_a) begin
      if (!in_a) begin
        exp_ra_rf = '0;
        exp_ra_wf = '0;
      end else begin
        exp_ra_rf = mem_m[int'(aa)];
        exp_ra_wf = (wr_bk && same) ? merge(mem_m[int'(aa)], db, bb) : mem_m[int'(aa)];
      end
    end
    if (rd_b) begin
      if (!in_b) begin
        exp_rb_rf = '0;
        exp_rb_wf = '0;
      end else begin
        exp_rb_rf = mem_m[int'(ab)];
        exp_rb_wf = (wr_a && same) ? merge(mem_m[int'(ab)], da, ba) : mem_m[int'(ab)];
      end
    end

    if (busy_m) begin
      mem_m[clr_pos] = '0;
      clr_pos++;
      if (clr_pos == DEPTH) begin
        clr_pos = -1;
        e_done  = 1'b1;
      end
    end else begin
      if (wr_bk) mem_m[int'(ab)] = merge(mem_m[int'(ab)], db, bb);
      if (wr_a)  mem_m[int'(aa)] = merge(mem_m[int'(aa)], da, ba);
      if (cr)    clr_pos = 0;
    end

    @(posedge clk);
    #1;
    check_all(rd_a, rd_b, e_coll, e_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
  task automatic do_reset();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0; clear_req = 0;
    rst = 1'b1;
    #1;
    clr_pos   = -1;
    exp_ra_rf = '0; exp_ra_wf = '0; exp_rb_rf = '0; exp_rb_wf = '0;
    check_all(0, 0, 0, 0);
    #1;
    rst = 1'b0;
  endtask

  logic          r_ea, r_wa, r_eb, r_wb, r_cr;
  logic [AW-1:0] r_aa, r_ab;
  logic [DW-1:0] r_da, r_db;
  logic [NB-1:0] r_ba, r_bb;

  task automatic randomize_inputs(input int clr_odds);
    r_ea = 1'($urandom_range(0, 1));
    r_wa = 1'($urandom_range(0, 1));
    r_eb = 1'($urandom_range(0, 1));
    r_wb = 1'($urandom_range(0, 1));
    r_aa = AW'($urandom_range(0, 19));
    r_ab = ($urandom_range(0, 3) == 0) ? r_aa : AW'($urandom_range(0, 19));
    r_da = DW'($urandom);
    r_db = DW'($urandom);
    r_ba = NB'($urandom_range(0, 3));
    r_bb = NB'($urandom_range(0, 3));
    r_cr = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 0; en_a = 0; we_a = 0; en_b = 0; we_b = 0; clear_req = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; wbe_a = '0; wbe_b = '0;
    clr_pos = -1;
    #2;
    do_reset();

    // Fill: A writes i+1, then B reads back
    for (int i = 0; i < DEPTH; i++) step(1, 1, AW'(i), DW'(i + 1), 2'b11, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, AW'(i), 0, 0, 0);
      check("fill_rd", rdata_b_rf, i + 1);
    end

    // Byte enables
    step(1, 1, 2, 16'hAAAA, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 16'h5555, 2'b01, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    check("be_merge", rdata_b_rf, 16'hAA55);

    // Cross-port read-during-write, both directions
    step(1, 1, 3, 16'h0011, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 16'h0022, 2'b11, 1, 0, 3, 0, 0, 0);
    check("xport_rf", rdata_b_rf, 16'h0011);
    check("xport_wf", rdata_b_wf, 16'h0022);
    step(1, 0, 3, 0, 0, 1, 1, 3, 16'h3344, 2'b10, 0);
    check("xport_ba_rf", rdata_a_rf, 16'h0022);
    check("xport_ba_wf", rdata_a_wf, 16'h3322);

    // Write/write collision
    step(1, 1, 5, 16'h000F, 2'b11, 1, 1, 5, 16'h00F0, 2'b11, 0);
    check("coll_pulse", coll_rf, 1);
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    check("coll_once", coll_rf, 0);
    check("coll_win", rdata_a_rf, 16'h000F);

    // Out of range: write dropped, read returns zero with valid
    step(1, 1, 20, 16'hBEEF, 2'b11, 1, 0, 4, 0, 0, 0);
    step(1, 0, 20, 0, 0, 1, 0, 31, 0, 0, 0);
    check("oor_rd", rdata_a_rf, 0);

    // Randomized traffic with occasional clears
    for (int n = 0; n < 300; n++) begin
      randomize_inputs(40);
      step(r_ea, r_wa, r_aa, r_da, r_ba, r_eb, r_wb, r_ab, r_db, r_bb, r_cr);
    end
    idle(DEPTH + 1);

    // Clear with a read accepted in the same cycle, random requests while busy
    step(1, 0, 1, 0, 0, 1, 1, 9, 16'h1234, 2'b11, 1);
    for (int n = 0; n < DEPTH; n++) begin
      randomize_inputs(3);
      r_ea = 1; r_eb = 1;
      step(r_ea, r_wa, r_aa, r_da, r_ba, r_eb, r_wb, r_ab, r_db, r_bb, r_cr);
    end
    check("clear_done_seen", done_rf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, AW'(DEPTH - 1 - i), 0, 0, 1, 0, AW'(i), 0, 0, 0);
      check("clr_zero", rdata_b_rf, 0);
    end

    // Refill, start a clear, reset at clear cycle 8
    for (int i = 0; i < DEPTH; i += 2) begin
      step(1, 1, AW'(i), DW'(16'h100 + i), 2'b11, 1, 1, AW'(i + 1), DW'(16'h100 + i + 1),
           2'b11, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(8);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, AW'(i), 0, 0, 0);
      check("rst_abort", rdata_b_rf, (i < 8) ? 0 : 16'h100 + i);
    end

    // More random traffic after the aborted clear
    for (int n = 0; n < 100; n++) begin
      randomize_inputs(30);
      step(r_ea, r_wa, r_aa, r_da, r_ba, r_eb, r_wb, r_ab, r_db, r_bb, r_cr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
